// File: rtl/serializer_pkg.sv
// Shared definitions for the PISO serializer: state encoding and state type.
package serializer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_LOAD = 2'b01;
    localparam state_t S_WAIT = 2'b10;
    localparam state_t S_SEND = 2'b11;

endpackage

// File: rtl/piso_serializer_if.sv
// Producer-side handshake and serial-link signals of the PISO serializer.
interface piso_serializer_if #(
    parameter int DATA_W = 16
);

    logic              start;
    logic [DATA_W-1:0] data_input;
    logic              ss;
    logic              data_output;
    logic              data_sent;
    logic              frame_done;
    logic              frame_abort;
    logic [1:0]        state_q;
    logic [DATA_W-1:0] shift_q;

    modport master (
        output start, data_input, ss,
        input  data_output, data_sent, frame_done, frame_abort, state_q, shift_q
    );

    modport slave (
        input  start, data_input, ss,
        output data_output, data_sent, frame_done, frame_abort, state_q, shift_q
    );

endinterface

// File: rtl/piso_shift_reg.sv
// Loadable shift register with zero-fill; tap is the bit at the output end.
module piso_shift_reg #(
    parameter int DATA_W    = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q,
    output logic              tap
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= LSB_FIRST ? (q >> 1) : (q << 1);
        end
    end

    assign tap = LSB_FIRST ? q[0] : q[DATA_W-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer framed by an active-low slave select.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              clock,
    input logic              resetn,
    piso_serializer_if.slave bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic              load;
    logic              shift;
    logic              tap;
    logic              last_bit;
    logic              abort_now;
    logic              done_now;
    logic              serial_bit;
    logic              frame_done;
    logic              frame_abort;

    // A rising ss while sending takes priority over finishing the frame.
    assign load      = (state == S_LOAD);
    assign last_bit  = (bit_cnt == LAST_CNT);
    assign abort_now = (state == S_SEND) && bus.ss;
    assign done_now  = (state == S_SEND) && !bus.ss && last_bit;
    assign shift     = (state == S_SEND) && !bus.ss && !last_bit;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_LOAD;
            S_LOAD:  state_next = S_WAIT;
            S_WAIT:  if (!bus.ss) state_next = S_SEND;
            S_SEND:  if (bus.ss || last_bit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            frame_done  <= done_now;
            frame_abort <= abort_now;
            if (load) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    piso_shift_reg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clock  (clock),
        .resetn (resetn),
        .load   (load),
        .shift  (shift),
        .din    (bus.data_input),
        .q      (shift_q),
        .tap    (tap)
    );

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^bus.data_input;
        end
    end

    // Once all data bits are out the counter sits at DATA_W for the parity slot.
    assign serial_bit = (bit_cnt == CNT_W'(DATA_W)) ? parity_q : tap;
`else
    assign serial_bit = tap;
`endif

    assign bus.data_output = ((state == S_WAIT) || (state == S_SEND)) ? serial_bit : 1'b0;
    assign bus.data_sent   = (state == S_IDLE);
    assign bus.frame_done  = frame_done;
    assign bus.frame_abort = frame_abort;
    assign bus.state_q     = state;
    assign bus.shift_q     = shift_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

- Parametrised parallel-in/serial-out serializer with handshake. Successor to the fixed 16-bit FSM serializer.
- Captures a DATA_W-bit word on `start`, waits for the slave-select line `ss` to go low, then shifts out one bit per clock.
- Adds configurable bit order, an automatic end-of-frame counter, and abort detection.
- Sits between a local producer and an off-chip slave-select-framed serial link.

## Interface
- DATA_W, 16, word width in bits; legal range 2..64.
- LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit DATA_W-1 sent first.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request to load `data_input`; sampled only in IDLE.
- data_input  in  DATA_W  parallel word; sampled at the edge leaving LOAD.
- ss  in  1  slave select, active-low frame enable.
- data_output  out  1  serial bit.
- data_sent  out  1  high in IDLE (ready for a new word).
- frame_done  out  1  one-cycle pulse after the last bit of a complete frame.
- frame_abort  out  1  one-cycle pulse when `ss` rises mid-SEND.
- state_q  out  2  current state (debug).
- shift_q  out  DATA_W  shift register contents (debug).

## Operation
- States and encodings: IDLE=00, LOAD=01, WAIT=10, SEND=11.
- IDLE:
  - `start`=1 → LOAD; otherwise stay.
  - `data_sent`=1 in IDLE only.
- LOAD: unconditional → WAIT; shift register <= `data_input`; bit counter <= 0.
- WAIT:
  - `ss`=0 → SEND; otherwise stay.
  - `data_output` already presents the first bit.
- SEND, at each edge:
  - `ss`=1 → IDLE; pulse `frame_abort`; shift register and counter are left unchanged.
  - Otherwise, if counter == FRAME_LEN-1 → IDLE; pulse `frame_done`.
  - Otherwise, shift toward the output end, zero-fill, counter +1.
- FRAME_LEN is DATA_W, or DATA_W+1 with parity (see Configuration).
- Counter width is $clog2(FRAME_LEN+1); the counter never wraps.
- `data_output` is shift_q[0] (LSB_FIRST=1) or shift_q[DATA_W-1] (LSB_FIRST=0) in WAIT/SEND, and 0 in IDLE/LOAD.
- Abort and last bit at the same edge: abort wins. `frame_done` is not pulsed.
- `start` outside IDLE is ignored. `ss` outside WAIT/SEND is ignored.
- Reset (at any time, including mid-frame):
  - state IDLE; shift register, counter, `frame_done`, `frame_abort` all 0.
  - Hence `data_output`=0 and `data_sent`=1.
  - `state_q`=00 and `shift_q`=0.

## Timing
- Edge E0 samples `start`=1; LOAD is active during E0→E1.
- E1 captures `data_input`; WAIT begins.
- The first edge with `ss`=0 in WAIT enters SEND.
- Bit k is valid on `data_output` from the WAIT→SEND edge (k=0) or the k-th SEND edge onward, for one cycle.
- Minimum start-to-idle latency: 3 + FRAME_LEN cycles, with `ss` already low.
- `frame_done` and `frame_abort` are registered and high exactly for the first IDLE cycle.
- A new `start` may be accepted in that same cycle.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - An even-parity bit (XOR of `data_input`) is captured in LOAD.
  - It is sent as an extra final bit after the data bits; FRAME_LEN = DATA_W+1.
  - The parity bit is held in a 1-bit register and muxed onto `data_output` when counter == DATA_W.
- Not defined: FRAME_LEN = DATA_W; no parity logic is present.

## Structure
- Package `serializer_pkg`: the state encoding constants (IDLE/LOAD/WAIT/SEND) and a 2-bit state typedef.
- Sub-module `piso_shift_reg` (DATA_W, LSB_FIRST): async-reset register with `load`/`shift` enables, zero-fill, and an output-bit tap.
- FSM, counter and pulse generation stay in the top module.

## Test plan
- Reset mid-SEND (DATA_W=16, data 16'hA5C3, after bit 5): drop `resetn` → `state_q`=00, `data_output`=0, `data_sent`=1 immediately (asynchronous).
- LSB_FIRST=1, 16'hA5C3, `ss` low throughout: bit stream 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; `frame_done` pulses once, 19 cycles after `start`.
- LSB_FIRST=0, 16'hA5C3: stream starts 1,0,1,0,0,1,0,1; `shift_q` is zero-filled from the LSB end.
- `ss` held high 10 cycles in WAIT: the FSM stays in WAIT, `data_output` = the first bit, no pulses.
- `ss` rises after 7 bits: → IDLE next edge; `frame_abort`=1 for one cycle; `frame_done` stays 0. The same abort on the last-bit edge also gives abort only.
- SERIALIZER_PARITY_EN, 16'h0001: 17 bits, final bit 1. With 16'h0003 the final bit is 0; `frame_done` fires after bit 16.
